ring_osc_freq_meter: RTL and testbench

Measures the frequency of one divided ring-oscillator output (`fast_clk[k]`) against the system clock. It counts the rising edges of that output during a fixed gate window of system-clock cycles and reports the count. Host logic (the SPI slave register file) uses the count to characterise the ring oscillator and choose a division tap. The block sits directly downstream of the ring oscillator and runs entirely in the `clk` domain; `osc_in` is treated as asynchronous.

---
 rtl/ring_osc_freq_meter.sv | 133 +++++++++++++
 tb/tb_ring_osc_freq_meter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
`timescale 1ns/1ps
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in
// over a gate window of GATE_CYCLES clk cycles. Single-shot or back-to-back windows.
// Ports: clk/reset_n, osc_in (async), start, continuous -> busy, done pulse, count, overflow.
module ring_osc_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   osc_in,
    input  logic                   start,
    input  logic                   continuous,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Two-flop synchronizer plus a history flop for edge detection.
    logic s1_q, s2_q, s3_q;
    logic rise;

    state_t                 state_q, state_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q, done_d;

    logic [COUNT_WIDTH-1:0] acc_sum;
    logic                   sat_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= osc_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Saturating accumulate including this edge's rise; sat_hit flags an
    // increment attempted while already at all-ones.
    always_comb begin
        sat_hit = rise & (&acc_q);
        acc_sum = acc_q;
        if (rise && !(&acc_q)) begin
            acc_sum = acc_q + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A rise on the accept edge is deliberately not accumulated.
                if (start) begin
                    state_d = ST_MEASURE;
                    gate_d  = GATE_LOAD;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                acc_d = acc_sum;
                sat_d = sat_q | sat_hit;
                if (gate_q != '0) begin
                    gate_d = gate_q - GW'(1);
                end else begin
                    // Final window edge: its rise is included in the result.
                    count_d    = acc_sum;
                    overflow_d = sat_q | sat_hit;
                    done_d     = 1'b1;
                    if (continuous) begin
                        gate_d = GATE_LOAD;
                        acc_d  = '0;
                        sat_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == ST_MEASURE);
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
`timescale 1ns/1ps
module tb_ring_osc_freq_meter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_v [2];
    logic        cont_v  [2];
    logic        man_v   [2];
    logic        gen_v   [2];
    int          per_v   [2];
    logic        osc_a, osc_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [15:0] count_a;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign osc_a = (per_v[0] != 0) ? gen_v[0] : man_v[0];
    assign osc_b = (per_v[1] != 0) ? gen_v[1] : man_v[1];

    ring_osc_freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(16)) u_main (
        .clk(clk), .reset_n(reset_n), .osc_in(osc_a), .start(start_v[0]),
        .continuous(cont_v[0]), .busy(busy_a), .done(done_a), .count(count_a),
        .overflow(ovf_a)
    );

    ring_osc_freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .osc_in(osc_b), .start(start_v[1]),
        .continuous(cont_v[1]), .busy(busy_b), .done(done_b), .count(count_b),
        .overflow(ovf_b)
    );

    // Periodic oscillator models, stepped on the falling clock edge.
    initial begin
        int ph [2];
        ph[0] = 0; ph[1] = 0;
        gen_v[0] = 1'b0; gen_v[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (per_v[i] > 0) begin
                    ph[i] = (ph[i] + 1) % per_v[i];
                    gen_v[i] = (ph[i] < per_v[i] / 2);
                end else begin
                    gen_v[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic int busy_of(input int s);
        return (s != 0) ? int'(busy_b) : int'(busy_a);
    endfunction
    function automatic int done_of(input int s);
        return (s != 0) ? int'(done_b) : int'(done_a);
    endfunction
    function automatic int count_of(input int s);
        return (s != 0) ? int'(count_b) : int'(count_a);
    endfunction
    function automatic int ovf_of(input int s);
        return (s != 0) ? int'(ovf_b) : int'(ovf_a);
    endfunction

    // Single-shot window with a periodic oscillator; checks length, busy, result.
    task automatic run_shot(input int s, input int per, input int lo, input int hi, input int ov);
        int n;
        bit bl;
        per_v[s] = per;
        tick_n(3 * per + 10);
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
        chk("shot_busy_rise", busy_of(s), 1);
        n = 0;
        bl = 1'b0;
        do begin
            tick();
            n++;
            if (done_of(s) == 0 && busy_of(s) == 0) bl = 1'b1;
        end while (done_of(s) == 0 && n < 300);
        chk("shot_len", n, 100);
        chk("shot_busy_window", int'(bl), 0);
        chk_rng("shot_count", count_of(s), lo, hi);
        chk("shot_overflow", ovf_of(s), ov);
        chk("shot_busy_fall", busy_of(s), 0);
        tick();
        chk("shot_done_pulse", done_of(s), 0);
    endtask

    typedef struct {
        int sel;
        int per;
        int lo;
        int hi;
        int ovf;
    } shot_vec_t;

    typedef struct {
        int roff;
        int exp_count;
    } edge_vec_t;

    initial begin
        shot_vec_t shots [8];
        edge_vec_t edges [6];
        int  n, sum;
        bit  bl, seen;

        shots[0] = '{0, 10, 10, 10, 0};
        shots[1] = '{0, 20,  5,  5, 0};
        shots[2] = '{0,  4, 25, 25, 0};
        shots[3] = '{1,  4,  7,  7, 1};
        shots[4] = '{1, 40,  2,  3, 0};
        shots[5] = '{1, 15,  6,  7, 0};
        shots[6] = '{1, 12,  7,  7, 1};
        shots[7] = '{1, 20,  5,  5, 0};

        // rise landing on edge roff relative to the accept edge (GATE_CYCLES = 100)
        edges[0] = '{0,   0};
        edges[1] = '{1,   1};
        edges[2] = '{50,  1};
        edges[3] = '{99,  1};
        edges[4] = '{100, 1};
        edges[5] = '{101, 0};

        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            cont_v[i]  = 1'b0;
            man_v[i]   = 1'b0;
            per_v[i]   = 4;
        end

        // Reset held with the oscillators toggling.
        tick_n(10);
        chk("rst_busy", int'(busy_a) + int'(busy_b), 0);
        chk("rst_done", int'(done_a) + int'(done_b), 0);
        chk("rst_count", int'(count_a) + int'(count_b), 0);
        chk("rst_overflow", int'(ovf_a) + int'(ovf_b), 0);
        reset_n = 1'b1;
        bl = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy_a || busy_b) bl = 1'b1;
            if (done_a || done_b) seen = 1'b1;
        end
        chk("idle_busy", int'(bl), 0);
        chk("idle_done", int'(seen), 0);

        for (int i = 0; i < 8; i++) begin
            run_shot(shots[i].sel, shots[i].per, shots[i].lo, shots[i].hi, shots[i].ovf);
        end

        // Edge placement around the window boundaries.
        per_v[0] = 0;
        man_v[0] = 1'b0;
        tick_n(6);
        for (int k = 0; k < 6; k++) begin
            for (int e = -4; e <= 100; e++) begin
                start_v[0] = (e == 0);
                man_v[0] = (e >= edges[k].roff - 2);
                tick();
            end
            start_v[0] = 1'b0;
            chk("edge_done", int'(done_a), 1);
            chk("edge_count", int'(count_a), edges[k].exp_count);
            chk("edge_busy", int'(busy_a), 0);
            man_v[0] = 1'b0;
            tick_n(6);
        end

        // Continuous mode, then drop continuous mid-window.
        per_v[0] = 5;
        cont_v[0] = 1'b1;
        tick_n(30);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        sum = 0;
        bl = 1'b0;
        for (int w = 0; w < 3; w++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (!busy_a) bl = 1'b1;
            end while (!done_a && n < 300);
            chk("cont_period", n, 100);
            chk("cont_count", int'(count_a), 20);
            sum += int'(count_a);
        end
        chk("cont_busy_held", int'(bl), 0);
        chk("cont_sum", sum, 60);
        tick_n(30);
        cont_v[0] = 1'b0;
        n = 30;
        do begin
            tick();
            n++;
        end while (!done_a && n < 300);
        chk("cont_last_period", n, 100);
        chk("cont_last_count", int'(count_a), 20);
        chk("cont_stop_busy", int'(busy_a), 0);
        tick();
        chk("cont_stop_idle", int'(busy_a) + int'(done_a), 0);

        // start held high across single-shot completion: one IDLE cycle.
        per_v[0] = 0;
        tick_n(5);
        start_v[0] = 1'b1;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_a && n < 300);
        chk("held_len", n, 100);
        chk("held_idle_gap", int'(busy_a), 0);
        tick();
        chk("held_rearm", int'(busy_a), 1);
        start_v[0] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_a && n < 300);
        chk("held_second_len", n, 100);

        // start pulse at T+20 while busy is ignored.
        per_v[0] = 10;
        tick_n(40);
        start_v[0] = 1'b1;
        tick();
        n = 0;
        do begin
            start_v[0] = (n == 19);
            tick();
            n++;
        end while (!done_a && n < 300);
        start_v[0] = 1'b0;
        chk("busy_start_len", n, 100);
        chk("busy_start_count", int'(count_a), 10);
        tick();
        chk("busy_start_not_queued", int'(busy_a), 0);

        // Reset asserted at T+60 discards the window.
        tick_n(5);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick_n(60);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_count", int'(count_a), 0);
        chk("midrst_done", int'(done_a), 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_a) seen = 1'b1;
        end
        reset_n = 1'b1;
        bl = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (done_a) seen = 1'b1;
            if (busy_a) bl = 1'b1;
        end
        chk("midrst_no_done", int'(seen), 0);
        chk("midrst_stay_idle", int'(bl), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
